// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial sequence generator.
//   state_e      : controller states (IDLE, SHIFT, GAP, DONE)
//   *_DEF        : default widths used by sequence_generator's parameters
package seq_gen_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int RPT_W_DEF   = 4;
  localparam int GAP_W_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sequence_generator.sv
// Serial pattern transmitter feeding the sequence-detector blocks.
// A pattern word is latched on start and shifted out MSB-first (bit len-1
// down to bit 0), one bit per cycle in which the sink is ready. The word is
// repeated rpt times with gap idle cycles between repetitions.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous reset, active-high
//   start      start request, only looked at in IDLE
//   pattern    sequence bits, active field pattern[len-1:0]
//   len        bits per repetition (values above MAX_LEN are clamped)
//   rpt        number of repetitions
//   gap        idle cycles between repetitions
//   ready      sink accepts the current bit when out_valid && ready
//   out        serial data bit
//   out_valid  out carries a valid bit
//   busy       high while shifting or in an inter-repetition gap
//   done       single-cycle completion pulse
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int RPT_W   = RPT_W_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [RPT_W-1:0]   rpt,
  input  logic [GAP_W-1:0]   gap,
  input  logic               ready,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  // Shift-based select keeps the index width independent of MAX_LEN.
  function automatic logic pick_bit(input logic [MAX_LEN-1:0] p,
                                    input logic [LEN_W-1:0]   i);
    logic [MAX_LEN-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [GAP_W-1:0]   gap_q;
  logic [LEN_W-1:0]   idx_q;
  logic [RPT_W-1:0]   rep_q;
  logic [GAP_W-1:0]   gcnt_q;
  logic               out_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               done_q;

  logic [LEN_W-1:0]   len_d;
  logic [LEN_W-1:0]   first_idx_d;
  logic [LEN_W-1:0]   reload_idx_d;

  assign len_d        = clamp_len(len);
  assign first_idx_d  = len_d - LEN_W'(1);
  assign reload_idx_d = len_q - LEN_W'(1);

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      rep_q       <= '0;
      gcnt_q      <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          if (start) begin
            pat_q <= pattern;
            len_q <= len_d;
            gap_q <= gap;
            if (len_d == '0 || rpt == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= SHIFT;
              idx_q       <= first_idx_d;
              rep_q       <= rpt;
              out_q       <= pick_bit(pattern, first_idx_d);
              out_valid_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end

        SHIFT: begin
          // Without ready everything holds, so no bit is ever skipped.
          if (ready) begin
            if (idx_q != '0) begin
              idx_q <= idx_q - LEN_W'(1);
              out_q <= pick_bit(pat_q, idx_q - LEN_W'(1));
            end else begin
              rep_q <= rep_q - RPT_W'(1);
              if (rep_q > RPT_W'(1)) begin
                if (gap_q != '0) begin
                  state_q     <= GAP;
                  gcnt_q      <= gap_q;
                  out_q       <= 1'b0;
                  out_valid_q <= 1'b0;
                end else begin
                  // Back-to-back repetition: reload without a bubble.
                  idx_q <= reload_idx_d;
                  out_q <= pick_bit(pat_q, reload_idx_d);
                end
              end else begin
                state_q     <= DONE;
                done_q      <= 1'b1;
                busy_q      <= 1'b0;
                out_q       <= 1'b0;
                out_valid_q <= 1'b0;
              end
            end
          end
        end

        GAP: begin
          // Counter runs independently of ready; exit after gap cycles.
          if (gcnt_q <= GAP_W'(1)) begin
            state_q     <= SHIFT;
            idx_q       <= reload_idx_d;
            out_q       <= pick_bit(pat_q, reload_idx_d);
            out_valid_q <= 1'b1;
          end else begin
            gcnt_q <= gcnt_q - GAP_W'(1);
          end
        end

        DONE: begin
          state_q     <= IDLE;
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator. The reference model expands each accepted
// configuration into a queue of per-cycle items (data bit or gap slot) and
// follows it as the sink accepts bits; hand-written literals pin key results.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] rpt = '0;
  logic [2:0] gap = '0;
  logic       ready = 1'b1;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  sequence_generator dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .rpt       (rpt),
    .gap       (gap),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Configuration handed from driver to model (driver-owned).
  logic [7:0] cfg_pat;
  int         cfg_len, cfg_rpt, cfg_gap;
  int         load_seq  = 0;
  int         flush_seq = 0;

  // Model state (owned by the compare process).
  int   mq[$];        // 0/1 = expected data bit, 2 = gap slot
  bit   done_pend = 0;
  int   load_seen = 0;
  int   flush_seen = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  bit   got[$];
  logic [2:0] det_sh = '0;
  bit   det3 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int packed_got();
    int v = 0;
    foreach (got[i]) v = (v << 1) | int'(got[i]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (flush_seq != flush_seen) begin
      flush_seen = flush_seq;
      mq.delete();
      done_pend = 0;
    end
    if (load_seq != load_seen) begin
      int l;
      load_seen = load_seq;
      mq.delete();
      got.delete();
      busy_cnt = 0;
      done_cnt = 0;
      det_sh   = '0;
      det3     = 0;
      l = (cfg_len > 8) ? 8 : cfg_len;
      if (l == 0 || cfg_rpt == 0) done_pend = 1;
      else begin
        for (int r = 0; r < cfg_rpt; r++) begin
          for (int b = l - 1; b >= 0; b--) mq.push_back(int'(cfg_pat[b]));
          if (r < cfg_rpt - 1)
            for (int g = 0; g < cfg_gap; g++) mq.push_back(2);
        end
      end
    end

    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (out_valid === 1'b1 && ready === 1'b1) begin
      got.push_back(out);
      det_sh = {det_sh[1:0], out};
      if (det_sh == 3'b111) det3 = 1;
    end

    if (done_pend) begin
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_vld", out_valid, 0);
      done_pend = 0;
    end else if (mq.size() > 0) begin
      if (mq[0] == 2) begin
        chk("gap_vld", out_valid, 0);
        chk("gap_out", out, 0);
        chk("gap_busy", busy, 1);
        chk("gap_done", done, 0);
        void'(mq.pop_front());
      end else begin
        chk("bit_vld", out_valid, 1);
        chk("bit_out", out, mq[0]);
        chk("bit_busy", busy, 1);
        chk("bit_done", done, 0);
        if (ready) void'(mq.pop_front());
      end
      if (mq.size() == 0) done_pend = 1;
    end else begin
      chk("idle_vld", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
  end

  // Present a configuration for one cycle, then scramble the inputs so the
  // run relies on the latched copy.
  task automatic go(input logic [7:0] p, input int l, input int r, input int g, input bit hold);
    @(posedge clk);
    #1;
    pattern = p;
    len     = 4'(l);
    rpt     = 4'(r);
    gap     = 3'(g);
    start   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cfg_pat = p;
    cfg_len = l;
    cfg_rpt = r;
    cfg_gap = g;
    load_seq++;
    pattern = ~p;
    len     = 4'd1;
    rpt     = 4'd7;
    gap     = 3'd5;
  endtask

  task automatic wait_end(input string nm);
    int n = 0;
    while ((load_seq != load_seen || mq.size() > 0 || done_pend) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, (n < 200), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);

    // Three ones, single repetition; bench-side detector sees "111"
    go(8'b0000_0111, 3, 1, 0, 0);
    wait_end("s1_end");
    chk("s1_bits", packed_got(), 32'b111);
    chk("s1_nbits", got.size(), 3);
    chk("s1_busy", busy_cnt, 3);
    chk("s1_detect", det3, 1);

    // Two repetitions with a two-cycle gap
    go(8'b1011_0000, 8, 2, 2, 0);
    wait_end("s2_end");
    chk("s2_bits", packed_got(), 32'hB0B0);
    chk("s2_busy", busy_cnt, 18);

    // Sink stalls three cycles on the second bit
    go(8'b0000_0111, 3, 1, 0, 0);
    @(posedge clk);
    #1 ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 ready = 1'b1;
    wait_end("s3_end");
    chk("s3_bits", packed_got(), 32'b111);
    chk("s3_busy", busy_cnt, 6);

    // Back-to-back repetitions, no gap
    go(8'b0000_0110, 3, 3, 0, 0);
    wait_end("s4_end");
    chk("s4_bits", packed_got(), 32'b110110110);
    chk("s4_busy", busy_cnt, 9);

    // len=0 and rpt=0 finish immediately
    go(8'hFF, 0, 3, 1, 0);
    wait_end("s5_end");
    chk("s5_busy", busy_cnt, 0);
    chk("s5_nbits", got.size(), 0);
    chk("s5_done", done_cnt, 1);
    go(8'hFF, 4, 0, 1, 0);
    wait_end("s6_end");
    chk("s6_busy", busy_cnt, 0);
    chk("s6_done", done_cnt, 1);

    // len above MAX_LEN is clamped to 8
    go(8'b1100_0011, 12, 1, 0, 0);
    wait_end("s7_end");
    chk("s7_bits", packed_got(), 32'hC3);
    chk("s7_busy", busy_cnt, 8);

    // start held high through the run: no restart, single done
    go(8'b0000_0101, 3, 1, 0, 1);
    begin
      int n = 0;
      while (done !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("s8_done_seen", (n < 50), 1);
    end
    start = 1'b0;
    wait_end("s8_end");
    repeat (3) @(posedge clk);
    #1;
    chk("s8_done_cnt", done_cnt, 1);
    chk("s8_busy", busy_cnt, 3);
    chk("s8_bits", packed_got(), 32'b101);

    // Reset in the middle of the second repetition
    go(8'b1011_0000, 8, 2, 2, 0);
    repeat (12) @(posedge clk);
    #1;
    rstn = 1'b1;
    flush_seq++;
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk);
    #1 rstn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt, 0);

    // Fresh start after the abort
    go(8'b0000_0111, 3, 1, 0, 0);
    wait_end("s9_end");
    chk("s9_bits", packed_got(), 32'b111);
    chk("s9_busy", busy_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
